// File: rtl/rotate_aligner.sv
// rotate_aligner: finds the transmitter's rotate-left amount by hunting for SYNC_WORD, then de-rotates the data stream.
// Optional ROT_ALIGN_LOSS_CNT_EN adds a saturating lock-loss counter output loss_cnt.
module rotate_aligner #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
    parameter int MAX_GAP = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       locked,
    output logic [$clog2(WIDTH)-1:0]   rot_amt
`ifdef ROT_ALIGN_LOSS_CNT_EN
    ,
    output logic [7:0]                 loss_cnt
`endif
);
    localparam int RW = $clog2(WIDTH);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [RW-1:0] K_LAST = RW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(MAX_GAP);
    typedef enum logic [1:0] {HUNT, SEARCH, LOCKED} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] cap_q, cap_d, out_data_q, out_data_d, dec;
    logic [RW-1:0] k_q, k_d, rot_q, rot_d;
    logic [GW-1:0] gap_q, gap_d;
    logic locked_q, locked_d, out_valid_q, out_valid_d;
`ifdef ROT_ALIGN_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;
    assign loss_cnt = loss_q;
`endif
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [RW-1:0] k);
        return WIDTH'({x, x} >> k);
    endfunction
    assign in_ready  = !rst && (state_q == HUNT || (state_q == LOCKED && (!out_valid_q || out_ready)));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign locked    = locked_q;
    assign rot_amt   = rot_q;
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        k_d         = k_q;
        rot_d       = rot_q;
        locked_d    = locked_q;
        gap_d       = gap_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
`ifdef ROT_ALIGN_LOSS_CNT_EN
        loss_d      = loss_q;
`endif
        dec         = rotr(in_data, rot_q);
        case (state_q)
            HUNT: if (in_valid) begin
                cap_d   = in_data;
                k_d     = '0;
                state_d = SEARCH;
            end
            SEARCH: if (rotr(cap_q, k_q) == SYNC_WORD) begin
                rot_d    = k_q;
                locked_d = 1'b1;
                gap_d    = '0;
                state_d  = LOCKED;
            end else if (k_q == K_LAST) begin
                state_d = HUNT;
            end else begin
                k_d = k_q + 1'b1;
            end
            LOCKED: if (in_valid && in_ready) begin
                if (dec == SYNC_WORD) begin
                    gap_d = '0;
                end else if (gap_q != GAP_MAX) begin
                    out_data_d  = dec;
                    out_valid_d = 1'b1;
                    gap_d       = gap_q + 1'b1;
                end else begin
                    // too many words without a marker: alignment is presumed lost
                    locked_d = 1'b0;
                    gap_d    = '0;
                    state_d  = HUNT;
`ifdef ROT_ALIGN_LOSS_CNT_EN
                    loss_d   = (loss_q == 8'hFF) ? loss_q : loss_q + 1'b1;
`endif
                end
            end
            default: state_d = HUNT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            cap_q       <= '0;
            k_q         <= '0;
            rot_q       <= '0;
            locked_q    <= 1'b0;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef ROT_ALIGN_LOSS_CNT_EN
            loss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            k_q         <= k_d;
            rot_q       <= rot_d;
            locked_q    <= locked_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef ROT_ALIGN_LOSS_CNT_EN
            loss_q      <= loss_d;
`endif
        end
    end
endmodule
